// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and memory-stall controller for a 5-stage pipeline.
// Drives the per-stage register enables and flushes, and the data-memory request.
// It handles three cases:
//   - freezing the pipeline while data memory is busy
//   - flushing on a taken branch
//   - inserting a bubble on a load-use hazard
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_rs, id_rt               source registers of the instruction in ID
//   idex_mem_read, idex_dest   load flag / destination of the instruction in EX
//   mem_branch_taken           taken branch resolved in MEM
//   mem_read, mem_write        memory access of the instruction in MEM
//   dmem_ack                   data memory completes the access this cycle
//   *_en, *_flush, dmem_req    combinational pipeline controls (0 while in reset)
//   err                        sticky memory-timeout error
//   stall_cnt                  saturating count of cycles with pc_en=0
//   state                      FSM state (RUN=0, MEM_WAIT=1, ERR=2)
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_dest,
  input  logic             mem_branch_taken,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             dmem_req,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   stall_q;

  logic mem_access;
  logic load_use;
  logic flow;

  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c, dmem_req_c;

  assign mem_access = mem_read | mem_write;
  assign load_use   = idex_mem_read && (idex_dest != 5'd0) &&
                      ((idex_dest == id_rs) || (idex_dest == id_rt));

  // State register, wait counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  // Next state and combinational pipeline controls
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    err_d         = err_q;
    flow          = 1'b0;
    dmem_req_c    = 1'b0;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    exmem_en_c    = 1'b0;
    memwb_en_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;

    case (state_q)
      RUN: begin
        dmem_req_c = mem_access;
        if (mem_access && !dmem_ack) begin
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end else begin
          flow = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req_c = mem_access;
        // An ack arriving on the timeout cycle still completes the access
        if (dmem_ack) begin
          state_d = RUN;
          wcnt_d  = '0;
          flow    = 1'b1;
        end else if (wcnt_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase

    // Pipeline is moving: branch flush beats load-use bubble
    if (flow) begin
      pc_en_c    = 1'b1;
      ifid_en_c  = 1'b1;
      idex_en_c  = 1'b1;
      exmem_en_c = 1'b1;
      memwb_en_c = 1'b1;
      if (mem_branch_taken) begin
        ifid_flush_c  = 1'b1;
        idex_flush_c  = 1'b1;
        exmem_flush_c = 1'b1;
      end else if (load_use) begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_flush_c = 1'b1;
      end
    end
  end

  // Saturating stall counter; not counted once in ERR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!pc_en_c && (state_q != ERR) && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  // Controls are forced low asynchronously while reset is asserted
  assign pc_en       = rst_n & pc_en_c;
  assign ifid_en     = rst_n & ifid_en_c;
  assign idex_en     = rst_n & idex_en_c;
  assign exmem_en    = rst_n & exmem_en_c;
  assign memwb_en    = rst_n & memwb_en_c;
  assign ifid_flush  = rst_n & ifid_flush_c;
  assign idex_flush  = rst_n & idex_flush_c;
  assign exmem_flush = rst_n & exmem_flush_c;
  assign dmem_req    = rst_n & dmem_req_c;

  assign err       = err_q;
  assign stall_cnt = stall_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a scoreboard queue of expected values.
module tb_pipeline_ctrl;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNT_W   = 16;

  localparam int K_CTL = 0;
  localparam int K_ST  = 1;
  localparam int K_ERR = 2;
  localparam int K_SC  = 3;

  // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl, dmem_req}
  localparam logic [8:0] C_ALL  = 9'b11111_000_0;
  localparam logic [8:0] C_ALLR = 9'b11111_000_1;
  localparam logic [8:0] C_FRZ  = 9'b00000_000_1;
  localparam logic [8:0] C_LU   = 9'b00111_010_0;
  localparam logic [8:0] C_LUR  = 9'b00111_010_1;
  localparam logic [8:0] C_BR   = 9'b11111_111_0;
  localparam logic [8:0] C_ZERO = 9'b00000_000_0;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_ERR = 2'd2;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, idex_dest;
  logic idex_mem_read, mem_branch_taken, mem_read, mem_write, dmem_ack;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, dmem_req, err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0] state;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .idex_mem_read(idex_mem_read), .idex_dest(idex_dest),
    .mem_branch_taken(mem_branch_taken),
    .mem_read(mem_read), .mem_write(mem_write), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .dmem_req(dmem_req), .err(err), .stall_cnt(stall_cnt), .state(state)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_sc   = 0;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      K_CTL:   return 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                           ifid_flush, idex_flush, exmem_flush, dmem_req});
      K_ST:    return 32'(state);
      K_ERR:   return 32'(err);
      default: return 32'(stall_cnt);
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic lr,
                        input logic [4:0] dest, input logic br, input logic mr,
                        input logic mw, input logic ack);
    id_rs = rs; id_rt = rt; idex_mem_read = lr; idex_dest = dest;
    mem_branch_taken = br; mem_read = mr; mem_write = mw; dmem_ack = ack;
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic step(input string tag, input logic [8:0] ctl, input logic [1:0] st,
                      input logic er, input int sc);
    push({tag, "_ctl"}, K_CTL, 32'(ctl));
    #1 check_all();
    @(posedge clk);
    #1;
    push({tag, "_state"}, K_ST, 32'(st));
    push({tag, "_err"},   K_ERR, 32'(er));
    push({tag, "_stall"}, K_SC, 32'(sc));
    check_all();
    @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    push({tag, "_ctl"},   K_CTL, 32'(C_ZERO));
    push({tag, "_state"}, K_ST, 32'(S_RUN));
    push({tag, "_err"},   K_ERR, 32'd0);
    push({tag, "_stall"}, K_SC, 32'd0);
    check_all();
    exp_sc = 0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    push("rst_ctl",   K_CTL, 32'(C_ZERO));
    push("rst_state", K_ST, 32'(S_RUN));
    push("rst_err",   K_ERR, 32'd0);
    push("rst_stall", K_SC, 32'd0);
    check_all();

    rst_n = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle", C_ALL, S_RUN, 1'b0, exp_sc);

    set_in(5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_sc++; step("lu_rt", C_LU, S_RUN, 1'b0, exp_sc);

    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_r0", C_ALL, S_RUN, 1'b0, exp_sc);

    set_in(5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_sc++; step("lu_rs", C_LU, S_RUN, 1'b0, exp_sc);

    set_in(5'd5, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("br_lu", C_BR, S_RUN, 1'b0, exp_sc);

    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("rd_fast", C_ALLR, S_RUN, 1'b0, exp_sc);

    // Read acked on the fourth cycle: three frozen cycles
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_sc++; step("rd_w0", C_FRZ, S_MW, 1'b0, exp_sc);
    exp_sc++; step("rd_w1", C_FRZ, S_MW, 1'b0, exp_sc);
    exp_sc++; step("rd_w2", C_FRZ, S_MW, 1'b0, exp_sc);
    dmem_ack = 1'b1;
    step("rd_ack", C_ALLR, S_RUN, 1'b0, exp_sc);

    // Ack cycle in MEM_WAIT still applies the load-use rule
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_sc++; step("mw_lu_w", C_FRZ, S_MW, 1'b0, exp_sc);
    set_in(5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_sc++; step("mw_lu_ack", C_LUR, S_RUN, 1'b0, exp_sc);

    // Ack on the last wait cycle wins over the timeout
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_sc++; step("aw_enter", C_FRZ, S_MW, 1'b0, exp_sc);
    tick(TIMEOUT - 2);
    exp_sc += TIMEOUT - 2;
    exp_sc++; step("aw_last", C_FRZ, S_MW, 1'b0, exp_sc);
    dmem_ack = 1'b1;
    step("aw_ack", C_ALLR, S_RUN, 1'b0, exp_sc);

    // Write never acked: timeout into ERR
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_sc++; step("to_enter", C_FRZ, S_MW, 1'b0, exp_sc);
    tick(TIMEOUT - 2);
    exp_sc += TIMEOUT - 2;
    exp_sc++; step("to_pre", C_FRZ, S_MW, 1'b0, exp_sc);
    exp_sc++; step("to_fire", C_FRZ, S_ERR, 1'b1, exp_sc);
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("err_hold", C_ZERO, S_ERR, 1'b1, exp_sc);
    check_async_reset("err_rst");

    // Reset asserted mid-MEM_WAIT drops dmem_req without a clock edge
    rst_n = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_sc++; step("mw_pre_rst", C_FRZ, S_MW, 1'b0, exp_sc);
    check_async_reset("mw_rst");

    rst_n = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst", C_ALL, S_RUN, 1'b0, exp_sc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
